// File: rtl/pc_seq.sv
// Instruction sequencer for the 16-bit mycpu core: fetch/decode/mem/exec/halt
// control, driving one PC action per retired instruction.
module pc_seq #(
  parameter int unsigned DW          = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          im_req,
  input  logic          im_ack,
  input  logic [DW-1:0] im_rdata,
  input  logic          z_in,
  output logic [1:0]    ps_out,
  output logic [DW-1:0] ia_out,
  output logic [3:0]    rs_addr,
  output logic          alu_en,
  output logic [3:0]    alu_op,
  output logic          dm_req,
  output logic          dm_we,
  input  logic          dm_ack,
  output logic          retire,
  output logic          illegal,
  output logic          halted,
  output logic          bus_err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [1:0] PS_NOP = 2'b00;
  localparam logic [1:0] PS_INC = 2'b01;
  localparam logic [1:0] PS_BRA = 2'b10;
  localparam logic [1:0] PS_JMP = 2'b11;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t        state, state_nx;
  logic [DW-1:0] instr;
  logic [3:0]    opcode;
  logic [7:0]    cnt, cnt_nx;
  logic          bus_err_q, bus_err_nx;
  logic          im_req_c;

  assign opcode = instr[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      instr     <= '0;
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bus_err_q <= bus_err_nx;
      if (state == S_FETCH && im_ack)
        instr <= im_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bus_err_nx = bus_err_q;
    im_req_c   = 1'b0;
    ps_out     = PS_NOP;
    alu_en     = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        im_req_c = 1'b1;
        if (im_ack)
          state_nx = S_DECODE;
      end
      S_DECODE: begin
        cnt_nx = '0;
        if (opcode == 4'h5 || opcode == 4'h6)
          state_nx = S_MEM;
        else
          state_nx = S_EXEC;
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = (opcode == 4'h6);
        if (dm_ack) begin
          state_nx = S_EXEC;
        end else if (cnt + 8'd1 == TIMEOUT) begin
          bus_err_nx = 1'b1;
          state_nx   = S_HALT;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (opcode)
          4'h0:    ps_out = PS_INC;
          4'h1: begin
            ps_out = PS_INC;
            alu_en = 1'b1;
          end
          4'h2:    ps_out = z_in ? PS_BRA : PS_INC;
          4'h3:    ps_out = z_in ? PS_INC : PS_BRA;
          4'h4:    ps_out = PS_JMP;
          4'h5,
          4'h6:    ps_out = PS_INC;
          4'hF: begin
            ps_out   = PS_NOP;
            state_nx = S_HALT;
          end
          default: begin
            ps_out  = PS_INC;
            illegal = 1'b1;
          end
        endcase
      end
      S_HALT: ;
      default: state_nx = S_FETCH;
    endcase
  end

  // FETCH is the reset state, so the request is also masked by rst_n to stay low during reset
  assign im_req  = im_req_c & rst_n;
  assign retire  = (ps_out != PS_NOP);
  assign halted  = (state == S_HALT);
  assign bus_err = bus_err_q;
  assign ia_out  = {{(DW-12){instr[11]}}, instr[11:0]};
  assign rs_addr = instr[11:8];
  assign alu_op  = instr[11:8];

endmodule

// File: tb/tb_pc_seq.sv
// Randomized self-checking bench for pc_seq against a transaction-level
// model of the fetch/decode/mem/exec flow.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_ack, z_in, dm_ack;
  logic [15:0] im_rdata;

  logic        im_req, alu_en, dm_req, dm_we, retire, illegal, halted, bus_err;
  logic [1:0]  ps_out;
  logic [15:0] ia_out;
  logic [3:0]  rs_addr, alu_op;

  logic        t_im_req, t_alu_en, t_dm_req, t_dm_we, t_retire, t_illegal, t_halted, t_bus_err;
  logic [1:0]  t_ps_out;
  logic [15:0] t_ia_out;
  logic [3:0]  t_rs_addr, t_alu_op;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pc_seq #(.DW(16), .MEM_TIMEOUT(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_ack(im_ack), .im_rdata(im_rdata),
    .z_in(z_in), .ps_out(ps_out), .ia_out(ia_out), .rs_addr(rs_addr),
    .alu_en(alu_en), .alu_op(alu_op), .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
    .retire(retire), .illegal(illegal), .halted(halted), .bus_err(bus_err)
  );

  // Short-timeout instance sharing all inputs, used for the bus-error path
  pc_seq #(.DW(16), .MEM_TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .im_req(t_im_req), .im_ack(im_ack), .im_rdata(im_rdata),
    .z_in(z_in), .ps_out(t_ps_out), .ia_out(t_ia_out), .rs_addr(t_rs_addr),
    .alu_en(t_alu_en), .alu_op(t_alu_op), .dm_req(t_dm_req), .dm_we(t_dm_we), .dm_ack(dm_ack),
    .retire(t_retire), .illegal(t_illegal), .halted(t_halted), .bus_err(t_bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_ps(input logic [3:0] op, input logic z);
    case (op)
      4'h2:    return z ? 2'b10 : 2'b01;
      4'h3:    return z ? 2'b01 : 2'b10;
      4'h4:    return 2'b11;
      4'hF:    return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [15:0] exp_off(input logic [15:0] ins);
    int v;
    v = int'(ins[11:0]);
    if (v >= 2048) v -= 4096;
    return 16'(v);
  endfunction

  // One instruction from FETCH to the cycle after EXEC; called at a negedge in FETCH
  task automatic do_instr(input logic [15:0] ins, input int unsigned im_wait,
                          input int unsigned dm_wait, input logic z);
    logic [3:0] op;
    logic [1:0] ps_e;
    op     = ins[15:12];
    ps_e   = exp_ps(op, z);
    z_in   = z;
    im_ack = 1'b0;
    dm_ack = 1'b0;
    for (int i = 0; i < int'(im_wait); i++) begin
      chk("fetch_wait_im_req", im_req, 1);
      chk("fetch_wait_ps", ps_out, 0);
      @(negedge clk);
    end
    chk("fetch_im_req", im_req, 1);
    chk("fetch_ps", ps_out, 0);
    im_ack   = 1'b1;
    im_rdata = ins;
    @(negedge clk);
    im_ack   = 1'($urandom);
    im_rdata = 16'($urandom);
    chk("dec_im_req", im_req, 0);
    chk("dec_ps", ps_out, 0);
    chk("dec_dm_req", dm_req, 0);
    chk("dec_retire", retire, 0);
    @(negedge clk);
    if (op == 4'h5 || op == 4'h6) begin
      for (int k = 0; k <= int'(dm_wait); k++) begin
        chk("mem_dm_req", dm_req, 1);
        chk("mem_dm_we", dm_we, (op == 4'h6));
        chk("mem_ps", ps_out, 0);
        im_ack   = 1'($urandom);
        im_rdata = 16'($urandom);
        dm_ack   = (k == int'(dm_wait));
        @(negedge clk);
      end
      dm_ack = 1'b0;
    end
    chk("exec_ps", ps_out, ps_e);
    chk("exec_retire", retire, (ps_e != 2'b00));
    chk("exec_alu_en", alu_en, (op == 4'h1));
    chk("exec_alu_op", alu_op, ins[11:8]);
    chk("exec_illegal", illegal, (op >= 4'h7 && op <= 4'hE));
    chk("exec_ia_out", ia_out, exp_off(ins));
    chk("exec_rs_addr", rs_addr, ins[11:8]);
    chk("exec_dm_req", dm_req, 0);
    chk("exec_im_req", im_req, 0);
    chk("exec_halted", halted, 0);
    @(negedge clk);
    im_ack = 1'b0;
    if (op == 4'hF)
      chk("post_halted", halted, 1);
    else
      chk("post_im_req", im_req, 1);
    chk("post_retire", retire, 0);
  endtask

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0; im_ack = 1'b0; im_rdata = '0; z_in = 1'b0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_im_req", im_req, 0);
    chk("rst_ps", ps_out, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_ia_out", ia_out, 0);
    chk("rst_alu_en", alu_en, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_im_req", im_req, 1);
    chk("rel_ps", ps_out, 0);
    chk("rel_retire", retire, 0);
    chk("rel_bus_err", bus_err, 0);

    repeat (3) do_instr(16'h0000, 0, 0, 1'b0);
    do_instr(16'h2FFE, 0, 0, 1'b1);
    do_instr(16'h2FFE, 0, 0, 1'b0);
    do_instr(16'h3010, 1, 0, 1'b0);
    do_instr(16'h4300, 0, 0, 1'b0);
    do_instr(16'h1A00, 0, 0, 1'b0);
    do_instr(16'h6000, 0, 5, 1'b0);
    do_instr(16'h5ABC, 2, 0, 1'b1);
    do_instr(16'h9123, 0, 0, 1'b0);
    do_instr(16'h2800, 0, 0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom));
    end

    do_instr(16'hF000, 0, 0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      im_ack   = 1'($urandom);
      im_rdata = 16'($urandom);
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_im_req", im_req, 0);
      chk("halt_ps", ps_out, 0);
      chk("halt_retire", retire, 0);
    end
    im_ack = 1'b0;

    // Bus timeout on the short-timeout instance; main instance keeps waiting in MEM
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("to_im_req", t_im_req, 1);
    im_ack = 1'b1; im_rdata = 16'h5123;
    @(negedge clk);
    im_ack = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("to_dm_req", t_dm_req, 1);
      chk("to_retire", t_retire, 0);
      chk("to_bus_err_early", t_bus_err, 0);
      @(negedge clk);
    end
    chk("to_dm_req_drop", t_dm_req, 0);
    chk("to_bus_err", t_bus_err, 1);
    chk("to_halted", t_halted, 1);
    chk("to_retire_end", t_retire, 0);
    chk("to_ps", t_ps_out, 0);
    chk("main_still_mem", dm_req, 1);
    repeat (3) @(negedge clk);
    chk("to_bus_err_sticky", t_bus_err, 1);
    chk("to_retire_never", t_retire, 0);

    // Asynchronous reset while the main instance is mid-MEM
    chk("async_pre_dm_req", dm_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dm_req", dm_req, 0);
    chk("async_im_req", im_req, 0);
    chk("async_bus_err", t_bus_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_im_req", im_req, 1);
    chk("after_bus_err", bus_err, 0);
    chk("after_halted", halted, 0);
    chk("after_t_bus_err", t_bus_err, 0);
    do_instr(16'h1500, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
